// File: rtl/f32_mult_feeder.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// f32_mult_feeder: operand-pair FIFO feeding an external FP32 multiplier (watchdog: F32_MULT_FEEDER_TIMEOUT_EN)
// Revision: 1.0
// ------------------------------------------------------------------------------------------
module f32_mult_feeder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        busy,
  output logic        err,
  output logic [15:0] result_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               mul_start_q, mul_start_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_p_q, out_p_d;
  logic               err_q, err_d;
  logic [15:0]        result_cnt_q, result_cnt_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               push, pop;

  logic [31:0]        fifo_a_mem [FIFO_DEPTH];
  logic [31:0]        fifo_b_mem [FIFO_DEPTH];

`ifdef F32_MULT_FEEDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    push         = in_valid && in_ready_q;
    pop          = 1'b0;
    state_d      = state_q;
    mul_start_d  = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    out_valid_d  = out_valid_q;
    out_p_d      = out_p_q;
    err_d        = err_q;
    result_cnt_d = result_cnt_q;
`ifdef F32_MULT_FEEDER_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef F32_MULT_FEEDER_TIMEOUT_EN
        wait_cnt_d = TO_W'(1);
`endif
      end
      WAIT: begin
        if (mul_done) begin
          out_p_d     = mul_p;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
`ifdef F32_MULT_FEEDER_TIMEOUT_EN
        // wait_cnt_q counts cycles elapsed since the start pulse
        else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
          out_p_d     = C_QNAN;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d  = 1'b0;
          result_cnt_d = result_cnt_q + 16'd1;
          if (count_q != '0) begin
            pop         = 1'b1;
            mul_start_d = 1'b1;
            state_d     = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      mul_a_d  = fifo_a_mem[rd_ptr_q];
      mul_b_d  = fifo_b_mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Status outputs are registered from next-state values so they track state_q/count_q exactly
    in_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    busy_d     = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_mem[wr_ptr_q] <= in_a;
      fifo_b_mem[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_p_q      <= '0;
      err_q        <= 1'b0;
      result_cnt_q <= '0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b1;
`ifdef F32_MULT_FEEDER_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mul_start_q  <= mul_start_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      out_valid_q  <= out_valid_d;
      out_p_q      <= out_p_d;
      err_q        <= err_d;
      result_cnt_q <= result_cnt_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
`ifdef F32_MULT_FEEDER_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign mul_start  = mul_start_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign out_valid  = out_valid_q;
  assign out_p      = out_p_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign result_cnt = result_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_f32_mult_feeder.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// tb_f32_mult_feeder: scoreboard bench with a table-driven multiplier model
// Revision: 1.0
// ------------------------------------------------------------------------------------------
module tb_f32_mult_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [31:0] mul_p = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_p;
  logic        busy, err;
  logic [15:0] result_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  int          hs_cyc[$];
  int          cyc = 0;
  int          lat = 1;
  bit          never_done = 1'b0;
  int          start_pulses = 0;

  f32_mult_feeder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .busy(busy), .err(err), .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Hand-computed FP32 products for every operand pair the bench issues
  function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40200000, 32'h40E00000}: return 32'h418C0000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      {32'h3F800000, 32'h40000000}: return 32'h40000000;
      {32'h3F800000, 32'h40400000}: return 32'h40400000;
      {32'h3F800000, 32'h40800000}: return 32'h40800000;
      {32'h3F800000, 32'h40A00000}: return 32'h40A00000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Multiplier model: done pulse 'lat' cycles after the start pulse
  initial begin : mult_model
    int          cnt;
    logic [31:0] p;
    logic        prev_start;
    cnt = 0; p = '0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        mul_done = 1'b0;
        prev_start = 1'b0;
      end else begin
        mul_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mul_done = 1'b1;
            mul_p = p;
          end
        end
        if (mul_start) begin
          start_pulses++;
          chk("mul_start_one_cycle", {31'd0, prev_start}, 32'd0);
          p = lookup(mul_a, mul_b);
          cnt = never_done ? 0 : lat;
        end
        prev_start = mul_start;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt = '0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid out_p=%h required=no_output", out_p);
        end else if (out_ready) begin
          chk("out_p", out_p, exp_q.pop_front());
          chk("result_cnt_before_handoff", {16'd0, result_cnt}, {16'd0, exp_cnt});
          exp_cnt++;
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; n = 0;
    while (!in_ready && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
    end else begin
      exp_q.push_back(p);
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      tick(1);
      n++;
    end
    if (n >= bound) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd1);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
    chk({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    chk({tag, "_out_p"},      out_p,               32'd0);
    chk({tag, "_mul_start"},  {31'd0, mul_start},  32'd0);
    chk({tag, "_mul_a"},      mul_a,               32'd0);
    chk({tag, "_mul_b"},      mul_b,               32'd0);
    chk({tag, "_err"},        {31'd0, err},        32'd0);
    chk({tag, "_result_cnt"}, {16'd0, result_cnt}, 32'd0);
  endtask

  initial begin : stimulus
    int sp, n, nh;
    logic [31:0] held;

    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single operation, 5-cycle multiplier
    lat = 5; out_ready = 1'b1; sp = start_pulses;
    push(32'h40200000, 32'h40E00000, 32'h418C0000);
    drain(100);
    chk("single_start_pulses", start_pulses - sp, 32'd1);
    chk("single_result_cnt", {16'd0, result_cnt}, 32'd1);
    chk("single_err", {31'd0, err}, 32'd0);

    // Fill the queue under backpressure, then release
    lat = 1; out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] bv;
      case (k)
        1: bv = 32'h3F800000;
        2: bv = 32'h40000000;
        3: bv = 32'h40400000;
        4: bv = 32'h40800000;
        default: bv = 32'h40A00000;
      endcase
      push(32'h3F800000, bv, bv);
    end
    chk("fill_in_ready_low", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin tick(1); n++; end
    chk("fill_out_valid_seen", {31'd0, out_valid}, 32'd1);
    held = out_p; sp = start_pulses;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("hold_out_p_stable", out_p, held);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    chk("hold_no_start", start_pulses - sp, 32'd0);
    chk("hold_queue_full", {31'd0, in_ready}, 32'd0);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    nh = hs_cyc.size();
    out_ready = 1'b1;
    drain(200);
    chk("fill_result_cnt", {16'd0, result_cnt}, 32'd6);
    if (hs_cyc.size() == nh + 5)
      chk("throughput_3cyc", {31'd0, (hs_cyc[nh+4] - hs_cyc[nh]) <= 12}, 32'd1);
    else
      chk("fill_handoffs", hs_cyc.size() - nh, 32'd5);

    // Reset while waiting on the multiplier with two pairs still queued
    lat = 30;
    push(32'h3F800000, 32'h40000000, 32'h40000000);
    push(32'h3F800000, 32'h40400000, 32'h40400000);
    push(32'h3F800000, 32'h40800000, 32'h40800000);
    tick(3);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1 check_reset_values("midop");
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    sp = start_pulses;
    tick(60);
    chk("post_reset_no_start", start_pulses - sp, 32'd0);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

`ifdef F32_MULT_FEEDER_TIMEOUT_EN
    never_done = 1'b1;
    push(32'h40200000, 32'h40E00000, 32'h7FC00000);
    drain(200);
    chk("timeout_err", {31'd0, err}, 32'd1);
    never_done = 1'b0; lat = 2;
    push(32'h3F800000, 32'h40400000, 32'h40400000);
    drain(100);
    chk("timeout_err_sticky", {31'd0, err}, 32'd1);
    chk("timeout_result_cnt", {16'd0, result_cnt}, 32'd2);
`else
    never_done = 1'b1;
    push(32'h40200000, 32'h40E00000, 32'h418C0000);
    tick(100);
    chk("no_timeout_still_waiting", {31'd0, busy}, 32'd1);
    chk("no_timeout_out_valid", {31'd0, out_valid}, 32'd0);
    chk("no_timeout_err", {31'd0, err}, 32'd0);
    never_done = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
`endif

    // Counter wrap at 0xFFFF -> 0x0000
    force dut.result_cnt_q = 16'hFFFF;
    tick(1);
    release dut.result_cnt_q;
    exp_cnt = 16'hFFFF;
    lat = 1;
    push(32'h3F800000, 32'h40A00000, 32'h40A00000);
    drain(100);
    chk("wrap_result_cnt", {16'd0, result_cnt}, 32'd0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
